// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Optional build macro: APPROX_DIV_TRUNC_EN (truncated quotient, fewer iterations).
package seq_restoring_divider_pkg;

  localparam int unsigned DW_N_DEF       = 16;
  localparam int unsigned DW_D_DEF       = 8;
  localparam int unsigned TRUNC_BITS_DEF = 4;

`ifdef APPROX_DIV_TRUNC_EN
  localparam bit TRUNC_EN = 1'b1;
`else
  localparam bit TRUNC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Number of quotient bits actually computed
  function automatic int unsigned iter_count(input int unsigned dw_n,
                                             input int unsigned trunc_bits);
    return TRUNC_EN ? (dw_n - trunc_bits) : dw_n;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned DW_D = 8
) (
  input  logic [DW_D:0]   prem_i,
  input  logic            bit_i,
  input  logic [DW_D-1:0] divisor_i,
  output logic [DW_D:0]   prem_o,
  output logic            qbit_o
);

  localparam int unsigned PW = DW_D + 1;

  logic [PW:0]   shifted;
  logic [PW-1:0] diff;

  // Trial subtraction; a surviving difference is always below the divisor
  always_comb begin
    shifted = {prem_i, bit_i};
    qbit_o  = (shifted >= (PW+1)'(divisor_i));
    diff    = shifted[PW-1:0] - PW'(divisor_i);
    prem_o  = qbit_o ? diff : shifted[PW-1:0];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// Optional build macro: APPROX_DIV_TRUNC_EN skips TRUNC_BITS quotient LSBs.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int unsigned DW_N       = DW_N_DEF,
  parameter int unsigned DW_D       = DW_D_DEF,
  parameter int unsigned TRUNC_BITS = TRUNC_BITS_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [DW_N-1:0] dividend,
  input  logic [DW_D-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [DW_N-1:0] quotient,
  output logic [DW_D-1:0] remainder,
  output logic            div_by_zero
);

  localparam int unsigned ITER = iter_count(DW_N, TRUNC_BITS);
  localparam int unsigned CW   = $clog2(DW_N + 1);
  localparam int unsigned PW   = DW_D + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW_N-1:0] sr_q, sr_d;
  logic [PW-1:0]   prem_q, prem_d;
  logic [DW_D-1:0] dvs_q, dvs_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW_N-1:0] quotient_q, quotient_d;
  logic [DW_D-1:0] remainder_q, remainder_d;
  logic            dbz_q, dbz_d;

  logic [PW-1:0]   step_prem;
  logic            step_qbit;
  logic [DW_N-1:0] sr_shift;

  div_step #(.DW_D(DW_D)) u_step (
    .prem_i    (prem_q),
    .bit_i     (sr_q[DW_N-1]),
    .divisor_i (dvs_q),
    .prem_o    (step_prem),
    .qbit_o    (step_qbit)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB
  always_comb begin
    sr_shift = {sr_q[DW_N-2:0], step_qbit};
  end

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    prem_d      = prem_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = dividend[DW_D-1:0];
            dbz_d       = 1'b1;
          end else begin
            state_d = S_CALC;
            sr_d    = dividend;
            prem_d  = '0;
            dvs_d   = divisor;
            cnt_d   = '0;
          end
        end
      end
      S_CALC: begin
        sr_d   = sr_shift;
        prem_d = step_prem;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d     = S_DONE;
          // In truncated mode the top bits still hold unused dividend LSBs
          quotient_d  = TRUNC_EN ? (sr_shift << TRUNC_BITS) : sr_shift;
          remainder_d = step_prem[DW_D-1:0];
          dbz_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      prem_q      <= '0;
      dvs_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      prem_q      <= prem_d;
      dvs_q       <= dvs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
